// File: rtl/spi_master.sv
// spi_master: 8-bit full-duplex SPI master (mode 0) with NUM_CS active-low
// chip selects. Each SPI half-period lasts CLK_DIV cycles of clk.
// Build option: define SPI_MSB_FIRST_EN to send and receive MSB first. When it
// is left undefined, bits go out and come in LSB first. Timing is the same in
// both builds.
//
// state | meaning
// IDLE  | waiting for start with a valid cs_sel
// SETUP | CS asserted, first MOSI bit driven, SCLK low
// HIGH  | SCLK high; MISO is sampled at the end of this phase
// LOW   | SCLK low, next MOSI bit driven
// HOLD  | SCLK low after the last bit, CS still asserted
// GAP   | CS deasserted; guarantees the minimum CS-high time
module spi_master #(
   parameter int CLK_DIV = 2,
   parameter int NUM_CS  = 2,
   parameter int CSW     = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [7:0]        tx_data,
   input  logic [CSW-1:0]    cs_sel,
   output logic              busy,
   output logic              done,
   output logic [7:0]        rx_data,
   output logic              SCLK,
   output logic              MOSI,
   input  logic              MISO,
   output logic [NUM_CS-1:0] CS_N
);

   localparam int HCW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int NSEL = 1 << CSW;
   // One bit per encodable cs_sel value; set where that index has a slave.
   localparam logic [NSEL-1:0] CS_OK = {NSEL{1'b1}} >> (NSEL - NUM_CS);

   typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;

   state_t            state_q, state_d;
   logic [HCW-1:0]    hc_q, hc_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        tx_q, tx_d;
   logic [7:0]        rx_sh_q, rx_sh_d;
   logic [7:0]        rx_data_q, rx_data_d;
   logic              sclk_q, sclk_d;
   logic              mosi_q, mosi_d;
   logic              done_q, done_d;
   logic [NUM_CS-1:0] cs_q, cs_d;
   logic              hc_last;
   logic              accept;

   // Position in the byte of the n-th bit on the wire.
   function automatic logic [2:0] bit_idx(input logic [2:0] n);
`ifdef SPI_MSB_FIRST_EN
      return 3'd7 - n;
`else
      return n;
`endif
   endfunction

   assign hc_last = (hc_q == HCW'(CLK_DIV - 1));
   assign accept  = start && CS_OK[cs_sel];

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         hc_q      <= '0;
         bit_q     <= '0;
         tx_q      <= '0;
         rx_sh_q   <= '0;
         rx_data_q <= '0;
         sclk_q    <= 1'b0;
         mosi_q    <= 1'b0;
         done_q    <= 1'b0;
         cs_q      <= '1;
      end else begin
         state_q   <= state_d;
         hc_q      <= hc_d;
         bit_q     <= bit_d;
         tx_q      <= tx_d;
         rx_sh_q   <= rx_sh_d;
         rx_data_q <= rx_data_d;
         sclk_q    <= sclk_d;
         mosi_q    <= mosi_d;
         done_q    <= done_d;
         cs_q      <= cs_d;
      end
   end

   // Next-state and next-output logic; every phase ends when hc wraps.
   always_comb begin
      state_d   = state_q;
      hc_d      = '0;
      bit_d     = bit_q;
      tx_d      = tx_q;
      rx_sh_d   = rx_sh_q;
      rx_data_d = rx_data_q;
      sclk_d    = sclk_q;
      mosi_d    = mosi_q;
      done_d    = 1'b0;
      cs_d      = cs_q;
      if (state_q != IDLE) begin
         hc_d = hc_last ? '0 : hc_q + 1'b1;
      end
      case (state_q)
         IDLE: begin
            if (accept) begin
               tx_d    = tx_data;
               cs_d    = ~(NUM_CS'(1) << cs_sel);
               mosi_d  = tx_data[bit_idx(3'd0)];
               bit_d   = '0;
               state_d = SETUP;
            end
         end
         SETUP, LOW: begin
            if (hc_last) begin
               sclk_d  = 1'b1;
               state_d = HIGH;
            end
         end
         HIGH: begin
            if (hc_last) begin
               sclk_d                  = 1'b0;
               rx_sh_d[bit_idx(bit_q)] = MISO;
               if (bit_q == 3'd7) begin
                  state_d = HOLD;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  mosi_d  = tx_q[bit_idx(bit_q + 3'd1)];
                  state_d = LOW;
               end
            end
         end
         HOLD: begin
            if (hc_last) begin
               cs_d      = '1;
               mosi_d    = 1'b0;
               rx_data_d = rx_sh_q;
               done_d    = 1'b1;
               state_d   = GAP;
            end
         end
         GAP: begin
            if (hc_last) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy    = (state_q != IDLE);
   assign done    = done_q;
   assign rx_data = rx_data_q;
   assign SCLK    = sclk_q;
   assign MOSI    = mosi_q;
   assign CS_N    = cs_q;

endmodule

// File: tb/tb_spi_master.sv
// Testbench for spi_master: behavioural mode-0 slaves on a wired-OR MISO bus,
// randomized transfers, timing derived from the 17-phase transfer length.
module tb_spi_master;

   localparam int D = 2;

   logic       clk = 1'b0;
   logic       rst_n, start, miso;
   logic [7:0] tx_data, rx_data;
   logic [0:0] cs_sel;
   logic       busy, done, sclk, mosi;
   logic [1:0] cs_n;

   logic       start3, miso3, busy3, done3, sclk3, mosi3;
   logic [7:0] tx3, rx3;
   logic [1:0] cs3;
   logic [2:0] cs_n3;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   spi_master #(.CLK_DIV(D), .NUM_CS(2)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .tx_data(tx_data), .cs_sel(cs_sel),
      .busy(busy), .done(done), .rx_data(rx_data), .SCLK(sclk), .MOSI(mosi),
      .MISO(miso), .CS_N(cs_n));

   spi_master #(.CLK_DIV(D), .NUM_CS(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .tx_data(tx3), .cs_sel(cs3),
      .busy(busy3), .done(done3), .rx_data(rx3), .SCLK(sclk3), .MOSI(mosi3),
      .MISO(miso3), .CS_N(cs_n3));

   // Wire position -> byte position for the selected bit order.
   function automatic int ord(input int j);
`ifdef SPI_MSB_FIRST_EN
      return 7 - j;
`else
      return j;
`endif
   endfunction

   // Behavioural slaves: load on CS fall, capture MOSI on SCLK rise,
   // advance MISO on SCLK fall, drive MISO only while selected.
   logic [7:0] slv_tx [2];
   logic [7:0] slv_rx [2];
   int         slv_bit [2];
   int         slv_xfers [2];
   logic [1:0] cs_prev = 2'b11;
   logic       sclk_prev = 1'b0;
   logic       mb [8];
   int         nrise = 0;

   always @(negedge clk) begin
      logic m;
      m = 1'b0;
      for (int s = 0; s < 2; s++) begin
         if (cs_prev[s] && !cs_n[s]) begin
            slv_bit[s] = 0;
            slv_rx[s]  = 8'h00;
            nrise      = 0;
         end
         if (!cs_n[s]) begin
            if (sclk && !sclk_prev && nrise < 8) begin
               mb[nrise] = mosi;
               slv_rx[s][ord(nrise)] = mosi;
               nrise++;
            end
            if (!sclk && sclk_prev) slv_bit[s]++;
            if (slv_bit[s] < 8) m = m | slv_tx[s][ord(slv_bit[s])];
         end
         if (!cs_prev[s] && cs_n[s]) slv_xfers[s]++;
      end
      miso      = m;
      cs_prev   = cs_n;
      sclk_prev = sclk;
   end

   // One transfer on dut, started at a negedge with dut idle; returns at the
   // first negedge with busy low.
   task automatic xfer(input int sel, input logic [7:0] tx, input logic [7:0] stx,
                       input bit hold, output int lat, output int cs_low,
                       output int rises, output int gap_high, output int extra_done,
                       output logic [1:0] cs_first);
      logic sp;
      slv_tx[sel] = stx;
      tx_data = tx; cs_sel = 1'(sel); start = 1'b1;
      lat = 0; cs_low = 0; rises = 0; gap_high = 0; extra_done = 0; cs_first = 2'b11;
      sp = sclk;
      for (int k = 1; k <= 400; k++) begin
         @(negedge clk);
         if (k == 1) cs_first = cs_n;
         if (!hold) start = 1'b0;
         tx_data = 8'($urandom);
         cs_sel  = 1'($urandom);
         if (cs_n[sel] == 1'b0) cs_low++;
         if (sclk && !sp) rises++;
         sp = sclk;
         if (done) begin
            lat = k;
            break;
         end
      end
      checks++;
      if (lat == 0) begin
         failures++;
         $display("FAIL xfer_timeout sel=%0d got no done required done", sel);
      end
      if (cs_n == 2'b11) gap_high = 1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (done) extra_done++;
         if (cs_n == 2'b11) gap_high++;
         if (!busy) break;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; start3 = 1'b0;
      tx_data = 8'h00; cs_sel = 1'b0; tx3 = 8'h00; cs3 = 2'd0; miso3 = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (cs_n !== 2'b11) begin failures++; $display("FAIL reset_cs_n got=%b exp=11", cs_n); end
      checks++; if (sclk !== 1'b0) begin failures++; $display("FAIL reset_sclk got=%b exp=0", sclk); end
      checks++; if (mosi !== 1'b0) begin failures++; $display("FAIL reset_mosi got=%b exp=0", mosi); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
      checks++; if (cs_n3 !== 3'b111) begin failures++; $display("FAIL reset_cs_n3 got=%b exp=111", cs_n3); end
   endtask

   task automatic test_basic();
      int lat, csl, ris, gh, xd;
      logic [1:0] cf;
      logic [7:0] tx;
      int bad;
      tx = 8'hab;
      xfer(0, tx, 8'hbc, 1'b0, lat, csl, ris, gh, xd, cf);
      checks++; if (cf !== 2'b10) begin failures++; $display("FAIL basic_cs_n got=%b exp=10", cf); end
      checks++; if (csl != 17*D) begin failures++; $display("FAIL basic_cs_low got=%0d exp=%0d", csl, 17*D); end
      checks++; if (ris != 8) begin failures++; $display("FAIL basic_sclk_rises got=%0d exp=8", ris); end
      checks++; if (lat != 17*D+1) begin failures++; $display("FAIL basic_done_latency got=%0d exp=%0d", lat, 17*D+1); end
      checks++; if (rx_data !== 8'hbc) begin failures++; $display("FAIL basic_rx_data got=%h exp=bc", rx_data); end
      checks++; if (slv_rx[0] !== 8'hab) begin failures++; $display("FAIL basic_slave_rx got=%h exp=ab", slv_rx[0]); end
      checks++; if (xd != 0) begin failures++; $display("FAIL basic_done_width got=%0d extra exp=0", xd); end
      checks++; if (gh != D+1) begin failures++; $display("FAIL basic_gap got=%0d exp=%0d", gh, D+1); end
      bad = 0;
      for (int i = 0; i < 8; i++) if (mb[i] !== tx[ord(i)]) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL basic_mosi_bits got=%0d wrong bits exp=0", bad); end
   endtask

   task automatic test_second_slave();
      int lat, csl, ris, gh, xd, x0;
      logic [1:0] cf;
      x0 = slv_xfers[0];
      slv_tx[0] = 8'hff;
      xfer(1, 8'hcd, 8'hde, 1'b0, lat, csl, ris, gh, xd, cf);
      checks++; if (cf !== 2'b01) begin failures++; $display("FAIL slave1_cs_n got=%b exp=01", cf); end
      checks++; if (rx_data !== 8'hde) begin failures++; $display("FAIL slave1_rx_data got=%h exp=de", rx_data); end
      checks++; if (slv_rx[1] !== 8'hcd) begin failures++; $display("FAIL slave1_slave_rx got=%h exp=cd", slv_rx[1]); end
      checks++; if (slv_xfers[0] != x0) begin failures++; $display("FAIL slave0_untouched got=%0d exp=%0d", slv_xfers[0], x0); end
   endtask

   task automatic test_busy_start();
      int lat, csl, ris, gh, xd, extra;
      logic [1:0] cf;
      logic [7:0] stx;
      stx = 8'($urandom);
      xfer(0, 8'h5a, stx, 1'b1, lat, csl, ris, gh, xd, cf);
      extra = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (busy || done || cs_n != 2'b11) extra++;
      end
      checks++; if (lat != 17*D+1) begin failures++; $display("FAIL busy_latency got=%0d exp=%0d", lat, 17*D+1); end
      checks++; if (xd != 0) begin failures++; $display("FAIL busy_extra_done got=%0d exp=0", xd); end
      checks++; if (extra != 0) begin failures++; $display("FAIL busy_queued got=%0d active cycles exp=0", extra); end
      checks++; if (rx_data !== stx) begin failures++; $display("FAIL busy_rx_data got=%h exp=%h", rx_data, stx); end
   endtask

   task automatic test_back_to_back();
      int lat, csl, ris, gh, xd;
      logic [1:0] cf;
      logic [7:0] s2;
      s2 = 8'($urandom);
      xfer(1, 8'($urandom), 8'($urandom), 1'b0, lat, csl, ris, gh, xd, cf);
      checks++; if (gh != D+1) begin failures++; $display("FAIL b2b_cs_high got=%0d exp=%0d", gh, D+1); end
      xfer(0, 8'h3c, s2, 1'b0, lat, csl, ris, gh, xd, cf);
      checks++; if (lat != 17*D+1) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=%0d", lat, 17*D+1); end
      checks++; if (rx_data !== s2) begin failures++; $display("FAIL b2b_rx_data got=%h exp=%h", rx_data, s2); end
      checks++; if (slv_rx[0] !== 8'h3c) begin failures++; $display("FAIL b2b_slave_rx got=%h exp=3c", slv_rx[0]); end
   endtask

   task automatic test_invalid_select();
      int bad, ok;
      start3 = 1'b1; cs3 = 2'd3; tx3 = 8'h77;
      @(negedge clk);
      start3 = 1'b0;
      bad = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (cs_n3 !== 3'b111 || busy3 || done3) bad++;
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL invalid_sel got=%0d active cycles exp=0", bad); end
      start3 = 1'b1; cs3 = 2'd2;
      @(negedge clk);
      start3 = 1'b0;
      checks++; if (cs_n3 !== 3'b011) begin failures++; $display("FAIL sel2_cs_n got=%b exp=011", cs_n3); end
      ok = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (!busy3) begin ok = 1; break; end
      end
      checks++; if (ok != 1) begin failures++; $display("FAIL sel2_timeout got busy exp idle"); end
   endtask

   task automatic test_bit_order();
      int lat, csl, ris, gh, xd;
      logic [1:0] cf;
      logic [7:0] tx;
      tx = 8'h01;
      xfer(0, tx, 8'h80, 1'b0, lat, csl, ris, gh, xd, cf);
      checks++; if (mb[0] !== tx[ord(0)]) begin failures++; $display("FAIL order_first_mosi got=%b exp=%b", mb[0], tx[ord(0)]); end
      checks++; if (mb[7] !== tx[ord(7)]) begin failures++; $display("FAIL order_last_mosi got=%b exp=%b", mb[7], tx[ord(7)]); end
      checks++; if (rx_data !== 8'h80) begin failures++; $display("FAIL order_rx_data got=%h exp=80", rx_data); end
   endtask

   task automatic test_random();
      int lat, csl, ris, gh, xd, sel;
      logic [1:0] cf;
      logic [7:0] tx, stx;
      for (int n = 0; n < 8; n++) begin
         sel = int'($urandom_range(0, 1));
         tx  = 8'($urandom);
         stx = 8'($urandom);
         xfer(sel, tx, stx, 1'b0, lat, csl, ris, gh, xd, cf);
         checks++; if (rx_data !== stx) begin failures++; $display("FAIL rand_rx_data n=%0d got=%h exp=%h", n, rx_data, stx); end
         checks++; if (slv_rx[sel] !== tx) begin failures++; $display("FAIL rand_slave_rx n=%0d got=%h exp=%h", n, slv_rx[sel], tx); end
         checks++; if (csl != 17*D) begin failures++; $display("FAIL rand_cs_low n=%0d got=%0d exp=%0d", n, csl, 17*D); end
         repeat (int'($urandom_range(0, 3))) @(negedge clk);
      end
   endtask

   task automatic test_reset_mid();
      int dn, bz;
      slv_tx[0] = 8'($urandom);
      tx_data = 8'hff; cs_sel = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checks++; if (cs_n !== 2'b11) begin failures++; $display("FAIL midrst_cs_n got=%b exp=11", cs_n); end
      checks++; if (sclk !== 1'b0) begin failures++; $display("FAIL midrst_sclk got=%b exp=0", sclk); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
      checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL midrst_rx_data got=%h exp=00", rx_data); end
      checks++; if (mosi !== 1'b0) begin failures++; $display("FAIL midrst_mosi got=%b exp=0", mosi); end
      dn = 0; bz = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done) dn++;
         if (busy) bz++;
      end
      checks++; if (dn != 0 || bz != 0) begin failures++; $display("FAIL midrst_after got=%0d done %0d busy exp=0", dn, bz); end
   endtask

   initial begin
      for (int s = 0; s < 2; s++) begin
         slv_tx[s] = 8'h00; slv_rx[s] = 8'h00; slv_bit[s] = 8; slv_xfers[s] = 0;
      end
      miso = 1'b0;
      test_reset();
      test_basic();
      test_second_slave();
      test_busy_start();
      test_back_to_back();
      test_invalid_select();
      test_bit_order();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
SPI bus master that initiates 8-bit full-duplex transfers to up to NUM_CS SPI_slave instances sharing SCLK/MOSI/MISO, one active-low chip select per slave.
- A local host issues start, tx_data and cs_sel, then receives rx_data and a done pulse.
- Default wire format is mode 0, LSB-first: SCLK idles low, MOSI changes while SCLK is low, data is sampled on the SCLK rising edge.
- Replaces the hand-written bit-bang sequencing currently done in benches.

Parameters:
CLK_DIV, 2, system clk cycles per SCLK half-period (>=1)
NUM_CS, 2, number of chip-select outputs (>=1)
CSW, $clog2(NUM_CS) (min 1), width of cs_sel

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  request a transfer; sampled only in IDLE
tx_data  in  8  byte to send, latched on accepted start
cs_sel  in  CSW  slave index, latched on accepted start
busy  out  1  high from cycle after accepted start until return to IDLE
done  out  1  one-cycle pulse, rx_data valid
rx_data  out  8  last received byte, held until next done
SCLK  out  1  SPI clock
MOSI  out  1  master-out data
MISO  in  1  master-in data (wired-OR bus)
CS_N  out  NUM_CS  active-low selects, one-hot-low when active

Behaviour:
- Reset (rst_n=0 at a clk edge, including mid-transfer): state=IDLE, CS_N=all 1, SCLK=0, MOSI=0, busy=0, done=0, rx_data=0, counters and shift registers cleared.
- Half-period counter hc counts 0..CLK_DIV-1; a phase ends when hc==CLK_DIV-1.
- States: IDLE, SETUP, HIGH, LOW, HOLD, GAP.
- IDLE: start=1 with cs_sel<NUM_CS is accepted. Next edge: latch tx_data into tx_sh, CS_N[cs_sel]=0, MOSI=tx_data[0], bit_cnt=0, busy=1, go SETUP.
- IDLE: start with cs_sel>=NUM_CS is ignored; no CS asserted, no done.
- SETUP: after CLK_DIV cycles, SCLK=1, go HIGH.
- HIGH: at phase end, SCLK=0 and rx_sh[bit_cnt]=MISO. MISO is sampled at the end of the high phase.
  - If bit_cnt==7, go HOLD.
  - Otherwise bit_cnt++, MOSI=tx_sh[bit_cnt+1], go LOW.
- LOW: after CLK_DIV cycles, SCLK=1, go HIGH.
- HOLD: after CLK_DIV cycles, CS_N=all 1, MOSI=0, rx_data=rx_sh, done=1 for one cycle, go GAP.
- GAP: after CLK_DIV cycles, busy=0, go IDLE. Guarantees a minimum CS-high time of CLK_DIV cycles.
- Timing:
  - CS_N low to CS_N high = 17*CLK_DIV cycles.
  - Accepted start to done = 17*CLK_DIV+1 cycles.
  - Exactly 8 SCLK rising edges per transfer.
- start while busy is ignored, not queued. start asserted in the same cycle busy falls is not accepted; it is accepted on the first cycle in IDLE.
- tx_data and cs_sel changes after acceptance have no effect on the current transfer.
- A new transfer can be accepted in the cycle after busy=0.

Optional Feature:
SPI_MSB_FIRST_EN
- Defined: bit order reversed. MOSI sends tx_data[7] first; the first sampled MISO bit lands in rx_data[7].
- Undefined: LSB-first as above.
- Timing is identical in both builds.

Test Plan:
1. Reset mid-transfer: CLK_DIV=2, start, then rst_n=0 at cycle 10 -> next edge CS_N=2'b11, SCLK=0, busy=0, rx_data=0; no done.
2. Basic transfer: CLK_DIV=2, start, cs_sel=0, tx_data=8'hab, slave 0 tx_mem=8'hbc ->
   - CS_N=2'b10 for 34 cycles, 8 SCLK pulses;
   - MOSI bits sampled at SCLK rises = 1,1,0,1,0,1,0,1;
   - done at cycle 35, rx_data=8'hbc;
   - slave rx_done=1 with received byte 8'hab.
3. Second slave: cs_sel=1, tx_data=8'hcd, slave 1 tx_mem=8'hde -> CS_N=2'b01, rx_data=8'hde, slave 0 MISO idle and slave 0 state unchanged.
4. Busy and back-to-back handling:
   - start pulses every cycle during a transfer -> exactly one transfer, one done.
   - back-to-back start in the cycle after busy falls -> CS_N high for at least 2 cycles between transfers.
5. Invalid select: NUM_CS=2, CSW=1 cannot encode an invalid index, so run at NUM_CS=3, CSW=2, cs_sel=3 -> no CS_N low, busy stays 0, no done.
6. SPI_MSB_FIRST_EN defined: tx_data=8'h01, slave returning 8'h80 -> MOSI first bit 0 and last bit 1; rx_data=8'h80 when slave also MSB-first loopback.
